dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port controller for the byte-addressable data memory. It arbitrates load/store requests from two requesters (port 0: core load/store stage, port 1: loader/debug port), formats RISC-V byte/halfword/word accesses into word-aligned memory cycles with byte enables, and returns sign- or zero-extended load data. It sits between the requesters and the data memory, which has a one-cycle synchronous read.

## Interface
- `ADDR_W`, default 32: request address width.
- `DATA_W`, default 32: data width. Fixed at 32; four byte lanes.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rK_valid`  in  1  request valid, for K = 0, 1.
- `rK_ready`  out  1  request accepted this cycle.
- `rK_we`  in  1  1 = store, 0 = load.
- `rK_addr`  in  ADDR_W  byte address.
- `rK_size`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `rK_wdata`  in  32  store data, right-justified.
- `rK_rsp_valid`  out  1  one-cycle response pulse.
- `rK_rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rK_rsp_err`  out  1  misaligned access or illegal size.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  write strobe.
- `mem_be`  out  4  byte enables; bit i = lane i = data[8i+7:8i].
- `mem_addr`  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read data, valid the cycle after `mem_en` with `mem_we` = 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `rK_valid` is high, grant one requester. Assert its `rK_ready` combinationally and latch we/addr/size/wdata and the grant ID.
  - Legal access → ISSUE.
  - Error → RESP with err = 1; no memory cycle.
- ISSUE: drive `mem_en` = 1 with the formatted signals.
  - Read → WAIT.
  - Write → RESP.
- WAIT: capture `mem_rdata` at the clock edge → RESP.
- RESP: pulse `rK_rsp_valid` for the granted K only → IDLE.
- `rK_ready` is high only in IDLE. A requester holds valid and all fields stable until ready.
- Arbitration is round-robin with a 1-bit priority pointer, reset value 0 (port 0 wins ties). After a grant to K, the pointer moves to the other port. Simultaneous requests alternate grants.
- Error conditions:
  - size ∈ {011, 110, 111};
  - size 11x or 100 with we = 1;
  - H/HU with addr[0] ≠ 0;
  - W with addr[1:0] ≠ 0.
- Byte enables, with o = addr[1:0]:
  - B: 4'b0001 << o.
  - H: 4'b0011 << o.
  - W: 4'b1111.
- Write data: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
- Load data: shift captured rdata right by 8·o, take the low 8/16/32 bits, then sign-extend (B, H) or zero-extend (BU, HU).
- `mem_*` outputs are 0 in every state except ISSUE.

## Timing
- Reset: state IDLE, pointer 0. All outputs 0: ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata.
- Load latency: accept at T, `mem_en` at T+1, rdata sampled at end of T+2, `rsp_valid` at T+3.
- Store latency: accept at T, `mem_en`/`mem_we` at T+1, `rsp_valid` at T+2.
- Error latency: accept at T, `rsp_valid` with err = 1 at T+1.
- Throughput: next accept no earlier than the cycle after RESP.
- Reset asserted mid-operation: transaction abandoned, no response pulse, all outputs zero immediately. Asserted during ISSUE, `mem_en` drops asynchronously.
- A valid arriving on the loser port during a busy transaction waits. No starvation: it is granted at the next IDLE.

## Structure
- Package `dmem_pkg` holds:
  - the state enum;
  - funct3 size constants;
  - functions `be_gen`, `wdata_rep`, `load_ext`.
- Sub-module `dmem_lane_fmt` is purely combinational: address/size/wdata/rdata → be, wdata, extended rdata, err. The arbiter FSM instantiates it once on the latched request.

## Test plan
- Port 0 LW addr 0x10, memory word 0xDEADBEEF → `mem_en` at T+1, `mem_be` = 1111, `r0_rsp_rdata` = 0xDEADBEEF at T+3.
- Port 1 SB addr 0x13, wdata 0x000000A5 → `mem_be` = 1000, `mem_wdata` = 0xA5A5A5A5, `r1_rsp_valid` at T+2. A follow-up LB 0x13 returns 0xFFFFFFA5; LBU returns 0x000000A5.
- LH addr 0x11 → err = 1 at T+1, `mem_en` never asserted, rdata = 0. Size 011 → err = 1.
- Both ports valid continuously with LW requests → grants go 0, 1, 0, 1 and each response appears only on the granted port.
- `rst_n` low during WAIT of a port-0 load → outputs 0 immediately, no `r0_rsp_valid`. After release, the next simultaneous request grants port 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state type, RISC-V
// funct3 access-size encodings and the lane formatting helpers used by
// dmem_lane_fmt.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_B, SZ_BU: be = 4'b0001 << off;
            SZ_H, SZ_HU: be = 4'b0011 << off;
            SZ_W:        be = 4'b1111;
            default:     be = '0;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across all lanes so the enabled
    // lanes carry the right bytes whatever the offset.
    function automatic logic [31:0] wdata_rep(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_B, SZ_BU: rep = {4{wdata[7:0]}};
            SZ_H, SZ_HU: rep = {2{wdata[15:0]}};
            SZ_W:        rep = wdata;
            default:     rep = '0;
        endcase
        return rep;
    endfunction

    // Align the addressed bytes to bit 0 and sign/zero extend.
    function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] ext;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_B:    ext = {{24{sh[7]}}, sh[7:0]};
            SZ_BU:   ext = {24'h0, sh[7:0]};
            SZ_H:    ext = {{16{sh[15]}}, sh[15:0]};
            SZ_HU:   ext = {16'h0, sh[15:0]};
            SZ_W:    ext = sh;
            default: ext = '0;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: request handshake
// (valid/ready with we/addr/size/wdata) and the one-cycle response
// (rsp_valid/rsp_rdata/rsp_err). master = requester, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [31:0]       wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output valid, we, addr, size, wdata,
        input  ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  valid, we, addr, size, wdata,
        output ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter.
//   in : we, off (addr[1:0]), size (funct3), wdata, rdata (raw memory word)
//   out: be, wdata_fmt (lane-replicated), rdata_ext (extended load), err
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_fmt,
    output logic [31:0] rdata_ext,
    output logic        err
);
    logic bad_size;
    logic bad_store;
    logic misaligned;

    assign be        = be_gen(size, off);
    assign wdata_fmt = wdata_rep(size, wdata);
    assign rdata_ext = load_ext(size, off, rdata);

    assign bad_size   = (size == 3'b011) || (size[2:1] == 2'b11);
    assign bad_store  = we && ((size[2:1] == 2'b11) || (size == SZ_BU));
    assign misaligned = (((size == SZ_H) || (size == SZ_HU)) && off[0])
                      || ((size == SZ_W) && (off != 2'b00));
    assign err        = bad_size || bad_store || misaligned;
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Round-robin grant between r0 and r1,
// RISC-V B/H/W access formatting onto a word-wide synchronous-read memory,
// and extended load data returned on the granted port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   r0, r1            : requester buses (slave side)
//   mem_en/we/be/addr/wdata : memory cycle, driven only in ISSUE
//   mem_rdata         : read data, valid the cycle after a read strobe
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     r0,
    dmem_arbiter_if.slave     r1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              any_valid, pick, accept;
    logic [3:0]        fmt_be;
    logic [31:0]       fmt_wdata, fmt_rdata;
    logic              fmt_err;
    logic              rsp_v, rsp_e;
    logic [31:0]       rsp_d;

    assign any_valid = r0.valid | r1.valid;
    // On a tie the pointer decides; otherwise the only valid port wins.
    assign pick      = (r0.valid & r1.valid) ? ptr_q : r1.valid;
    assign accept    = (state_q == ST_IDLE) & any_valid;

    // The formatter sees the request as it will be latched, so the error
    // verdict is already available in the accept cycle; outside IDLE these
    // equal the held request.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = pick ? r1.we    : r0.we;
            addr_d  = pick ? r1.addr  : r0.addr;
            size_d  = pick ? r1.size  : r0.size;
            wdata_d = pick ? r1.wdata : r0.wdata;
        end
    end

    dmem_lane_fmt u_fmt (
        .we        (we_d),
        .off       (addr_d[1:0]),
        .size      (size_d),
        .wdata     (wdata_d),
        .rdata     (rdata_q),
        .be        (fmt_be),
        .wdata_fmt (fmt_wdata),
        .rdata_ext (fmt_rdata),
        .err       (fmt_err)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_v     = 1'b0;
        rsp_e     = 1'b0;
        rsp_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gnt_d   = pick;
                    ptr_d   = ~pick;
                    err_d   = fmt_err;
                    state_d = fmt_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_be    = fmt_be;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata = we_q ? fmt_wdata : '0;
                state_d   = we_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                rdata_d = mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_v   = 1'b1;
                rsp_e   = err_q;
                rsp_d   = (err_q || we_q) ? '0 : fmt_rdata;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rst_n gating keeps ready low while reset is held even if a requester
    // is already presenting a request.
    assign r0.ready     = rst_n & accept & ~pick;
    assign r1.ready     = rst_n & accept & pick;
    assign r0.rsp_valid = rsp_v & ~gnt_q;
    assign r1.rsp_valid = rsp_v & gnt_q;
    assign r0.rsp_err   = rsp_e & ~gnt_q;
    assign r1.rsp_err   = rsp_e & gnt_q;
    assign r0.rsp_rdata = gnt_q ? '0 : rsp_d;
    assign r1.rsp_rdata = gnt_q ? rsp_d : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed test-plan cases, a
// randomized two-port phase and mid-transaction resets, all checked
// against a byte-array reference memory and arbitration model.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32)) r0_if ();
    dmem_arbiter_if #(.ADDR_W(32)) r1_if ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0        (r0_if),
        .r1        (r1_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [139:0] all_outs();
        return {r0_if.ready, r0_if.rsp_valid, r0_if.rsp_err, r0_if.rsp_rdata,
                r1_if.ready, r1_if.rsp_valid, r1_if.rsp_err, r1_if.rsp_rdata,
                mem_en, mem_we, mem_be, mem_addr, mem_wdata};
    endfunction

    // Memory seen by the DUT: one-cycle synchronous read, garbage otherwise.
    logic [31:0] mem_arr [0:63];
    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int l = 0; l < 4; l++)
                if (mem_be[l]) mem_arr[mem_addr[7:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
        mem_rdata <= (mem_en && !mem_we) ? mem_arr[mem_addr[7:2]] : $urandom;
    end

    // Reference model state.
    logic [7:0]  ref_mem [0:255];
    int          cyc = 0;
    int          mem_exp_cyc = -1;
    int          rsp_exp_cyc = -1;
    int          rsp_port = 0;
    logic        rsp_err_m = 1'b0;
    logic [31:0] rsp_data_m = '0;
    logic [69:0] mem_exp_m = '0;
    logic        ptr_m = 1'b0;
    int          acc_cnt [2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic        v0, v1, we, err, sgn;
        logic [31:0] a, wd, ld, rep;
        logic [2:0]  sz;
        logic [3:0]  be;
        int          g, n;
        if (!rst_n) begin
            check_eq("reset_outputs", all_outs(), '0);
            mem_exp_cyc = -1;
            rsp_exp_cyc = -1;
            ptr_m       = 1'b0;
        end else begin
            v0 = r0_if.valid;
            v1 = r1_if.valid;
            if (cyc > rsp_exp_cyc && (v0 || v1)) begin
                g = (v0 && v1) ? int'(ptr_m) : (v1 ? 1 : 0);
                check_eq("grant", {r0_if.ready, r1_if.ready}, (g == 0) ? 2'b10 : 2'b01);
                ptr_m = (g == 0);
                acc_cnt[g]++;
                we = g ? r1_if.we    : r0_if.we;
                a  = g ? r1_if.addr  : r0_if.addr;
                sz = g ? r1_if.size  : r0_if.size;
                wd = g ? r1_if.wdata : r0_if.wdata;
                sgn = 1'b0;
                case (sz)
                    3'd0: begin n = 1; sgn = 1'b1; end
                    3'd1: begin n = 2; sgn = 1'b1; end
                    3'd2: n = 4;
                    3'd4: n = 1;
                    3'd5: n = 2;
                    default: n = 0;
                endcase
                err = (n == 0) ? 1'b1 : ((we && sz == 3'd4) || (a % n != 0));
                rsp_port = g;
                if (err) begin
                    mem_exp_cyc = -1;
                    rsp_exp_cyc = cyc + 1;
                    rsp_err_m   = 1'b1;
                    rsp_data_m  = '0;
                end else begin
                    be = '0;
                    for (int i = 0; i < n; i++) be[(a % 4) + i] = 1'b1;
                    for (int l = 0; l < 4; l++) rep[8*l +: 8] = wd[8*(l % n) +: 8];
                    mem_exp_cyc = cyc + 1;
                    mem_exp_m   = {1'b1, we, be, a & ~32'h3, we ? rep : 32'h0};
                    rsp_err_m   = 1'b0;
                    if (we) begin
                        for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = wd[8*i +: 8];
                        rsp_exp_cyc = cyc + 2;
                        rsp_data_m  = '0;
                    end else begin
                        ld = '0;
                        for (int i = 0; i < n; i++) ld[8*i +: 8] = ref_mem[(a + i) % 256];
                        if (sgn && ld[8*n-1]) ld = ld | ~((32'h1 << (8*n)) - 32'h1);
                        rsp_exp_cyc = cyc + 3;
                        rsp_data_m  = ld;
                    end
                end
            end else begin
                check_eq("ready_idle", {r0_if.ready, r1_if.ready}, 2'b00);
            end
            if (cyc == mem_exp_cyc)
                check_eq("mem_cycle", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, mem_exp_m);
            else
                check_eq("mem_quiet", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, '0);
            check_eq("rsp0", {r0_if.rsp_valid, r0_if.rsp_err, r0_if.rsp_rdata},
                     (cyc == rsp_exp_cyc && rsp_port == 0) ? {1'b1, rsp_err_m, rsp_data_m} : 34'h0);
            check_eq("rsp1", {r1_if.rsp_valid, r1_if.rsp_err, r1_if.rsp_rdata},
                     (cyc == rsp_exp_cyc && rsp_port == 1) ? {1'b1, rsp_err_m, rsp_data_m} : 34'h0);
        end
    end

    task automatic drive(input int k, input logic v, input logic we, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd);
        if (k == 0) begin
            r0_if.valid = v; r0_if.we = we; r0_if.addr = a; r0_if.size = sz; r0_if.wdata = wd;
        end else begin
            r1_if.valid = v; r1_if.we = we; r1_if.addr = a; r1_if.size = sz; r1_if.wdata = wd;
        end
    endtask

    // Called and returns #1 after a rising edge.
    task automatic send(input int k, input logic we, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
        int base;
        base = acc_cnt[k];
        drive(k, 1'b1, we, a, sz, wd);
        for (int t = 0; t < 40 && acc_cnt[k] == base; t++) @(posedge clk);
        #1;
        check_eq("accept", acc_cnt[k] - base, 1);
        drive(k, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rand_req(input int k);
        logic [2:0]  sz;
        logic [31:0] a;
        case ($urandom_range(0, 12))
            0, 1:    sz = 3'd0;
            2, 3:    sz = 3'd1;
            4, 5, 6: sz = 3'd2;
            7, 8:    sz = 3'd4;
            9, 10:   sz = 3'd5;
            11:      sz = 3'd3;
            default: sz = ($urandom_range(0, 1) != 0) ? 3'd6 : 3'd7;
        endcase
        a = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0) begin
            if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
            if (sz == 3'd2) a[1:0] = 2'b00;
        end
        drive(k, 1'b1, $urandom_range(0, 1) != 0, a, sz, $urandom);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen [2];
        int g, prev_g, b0, b1, t;
        logic [31:0] w;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 64; i++) begin
            w = (i == 4) ? 32'hDEADBEEF : $urandom;
            mem_arr[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("reset_state", all_outs(), '0);

        // Test-plan cases.
        send(0, 1'b0, 32'h10, 3'b010, '0);
        idle_cycles(4);
        send(1, 1'b1, 32'h13, 3'b000, 32'h000000A5);
        send(1, 1'b0, 32'h13, 3'b000, '0);
        send(1, 1'b0, 32'h13, 3'b100, '0);
        send(0, 1'b0, 32'h11, 3'b001, '0);
        send(0, 1'b0, 32'h20, 3'b011, '0);
        idle_cycles(4);

        // Both ports continuously requesting loads must alternate.
        drive(0, 1'b1, 1'b0, 32'h40, 3'b010, '0);
        drive(1, 1'b1, 1'b0, 32'h44, 3'b010, '0);
        prev_g = 0;
        for (int i = 0; i < 8; i++) begin
            b0 = acc_cnt[0];
            b1 = acc_cnt[1];
            t  = 0;
            while (acc_cnt[0] == b0 && acc_cnt[1] == b1 && t < 40) begin
                @(posedge clk);
                t++;
            end
            #1;
            g = (acc_cnt[1] != b1) ? 1 : 0;
            check_eq("grant_event", (acc_cnt[0] - b0) + (acc_cnt[1] - b1), 1);
            if (i > 0) check_eq("alternate", g, prev_g ^ 1);
            prev_g = g;
            drive(g, 1'b1, 1'b0, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 3'b010, '0);
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle_cycles(5);

        // Random two-port traffic.
        seen = acc_cnt;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!(k ? r1_if.valid : r0_if.valid) || acc_cnt[k] != seen[k]) begin
                    seen[k] = acc_cnt[k];
                    if ($urandom_range(0, 3) != 0) rand_req(k);
                    else drive(k, 1'b0, 1'b0, '0, '0, '0);
                end
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle_cycles(6);

        // Reset while a port-0 load waits for read data.
        send(0, 1'b0, 32'h10, 3'b010, '0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_wait_outputs", all_outs(), '0);
        idle_cycles(2);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h18, 3'b010, '0);
        drive(1, 1'b1, 1'b0, 32'h1C, 3'b010, '0);
        #1 check_eq("post_reset_grant", {r0_if.ready, r1_if.ready}, 2'b10);
        b0 = acc_cnt[0];
        for (int i = 0; i < 40 && acc_cnt[0] == b0; i++) @(posedge clk);
        #1;
        check_eq("post_reset_accept", acc_cnt[0] - b0, 1);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle_cycles(6);

        // Reset while a load is in its memory-issue cycle.
        send(1, 1'b0, 32'h20, 3'b010, '0);
        check_eq("issue_mem_en", mem_en, 1'b1);
        rst_n = 1'b0;
        #1 check_eq("rst_issue_mem_en", mem_en, 1'b0);
        idle_cycles(2);
        rst_n = 1'b1;
        send(1, 1'b0, 32'h13, 3'b000, '0);
        idle_cycles(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
